// File: rtl/kmap_sweeper_if.sv
// kmap_sweeper_if: groups the sweep request, function-under-test stimulus and
// response, and the status/result signals of kmap_sweeper.
//   start     : sweep request (master -> slave)
//   f_in      : response F of the function under test (master -> slave)
//   abcd      : stimulus vector {A,B,C,D} (slave -> master)
//   busy      : sweep in progress (slave -> master)
//   done      : one-cycle end-of-sweep pulse (slave -> master)
//   table_out : captured truth table, bit i = F(abcd==i) (slave -> master)
//   exp_mask  : expected truth table, only with SWEEP_CMP_EN (master -> slave)
//   mismatch  : captured table differs from exp_mask, only with SWEEP_CMP_EN
// Optional feature macro: SWEEP_CMP_EN.
interface kmap_sweeper_if;
  localparam int unsigned VecW = 4;
  localparam int unsigned TblW = 16;

  logic            start;
  logic            f_in;
  logic [VecW-1:0] abcd;
  logic            busy;
  logic            done;
  logic [TblW-1:0] table_out;
`ifdef SWEEP_CMP_EN
  logic [TblW-1:0] exp_mask;
  logic            mismatch;

  modport master (output start, f_in, exp_mask,
                  input  abcd, busy, done, table_out, mismatch);
  modport slave  (input  start, f_in, exp_mask,
                  output abcd, busy, done, table_out, mismatch);
`else
  modport master (output start, f_in,
                  input  abcd, busy, done, table_out);
  modport slave  (input  start, f_in,
                  output abcd, busy, done, table_out);
`endif
endinterface

// File: rtl/kmap_sweeper.sv
// kmap_sweeper: walks a 4-input function through all 16 input vectors,
// waiting SETTLE cycles per vector before sampling its response, and builds
// the 16-bit truth table. Optional comparison against an expected table is
// enabled by defining macro SWEEP_CMP_EN.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : kmap_sweeper_if.slave (start, f_in, abcd, busy, done, table_out,
//           and exp_mask/mismatch when SWEEP_CMP_EN is defined)
// Parameter:
//   SETTLE : wait cycles per vector before capture, 1..15
module kmap_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  kmap_sweeper_if.slave bus
);

  localparam int unsigned IdxW = 4;
  localparam int unsigned CntW = 4;
  localparam int unsigned TblW = 16;

  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(TblW - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  state_t          stateQ, stateD;
  logic [IdxW-1:0] idxQ, idxD;
  logic [CntW-1:0] cntQ, cntD;
  logic [TblW-1:0] tableQ, tableD;
  logic            busyQ, busyD;
  logic            doneQ, doneD;
`ifdef SWEEP_CMP_EN
  logic            mismQ, mismD;
`endif

  // Next-state and datapath update
  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    cntD   = cntQ;
    tableD = tableQ;
`ifdef SWEEP_CMP_EN
    mismD  = mismQ;
`endif
    case (stateQ)
      ST_IDLE: begin
        if (bus.start) begin
          idxD   = '0;
          cntD   = '0;
          tableD = '0;
`ifdef SWEEP_CMP_EN
          mismD  = 1'b0;
`endif
          stateD = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cntD = cntQ + CntW'(1);
        if (cntQ == CntLast) begin
          stateD = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        tableD[idxQ] = bus.f_in;
        if (idxQ == IdxLast) begin
          // Vector 15 ends the sweep; idx/abcd stay at 4'hF.
          stateD = ST_FINISH;
`ifdef SWEEP_CMP_EN
          // Compare includes the sample written this cycle.
          mismD  = (tableD != bus.exp_mask);
`endif
        end else begin
          idxD   = idxQ + IdxW'(1);
          cntD   = '0;
          stateD = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase

    // Status flags are registered from the upcoming state
    busyD = (stateD == ST_SETTLE) || (stateD == ST_CAPTURE);
    doneD = (stateD == ST_FINISH);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= ST_IDLE;
      idxQ   <= '0;
      cntQ   <= '0;
      tableQ <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
`ifdef SWEEP_CMP_EN
      mismQ  <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      cntQ   <= cntD;
      tableQ <= tableD;
      busyQ  <= busyD;
      doneQ  <= doneD;
`ifdef SWEEP_CMP_EN
      mismQ  <= mismD;
`endif
    end
  end

  // abcd always tracks the vector index register
  assign bus.abcd      = idxQ;
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.table_out = tableQ;
`ifdef SWEEP_CMP_EN
  assign bus.mismatch  = mismQ;
`endif

endmodule

// File: tb/tb_kmap_sweeper.sv
// tb_kmap_sweeper: directed self-checking bench for kmap_sweeper.
// dut1 uses SETTLE=1 and is driven by the model F = ABC'D + B'D' + CD'
// (truth table 16'h6545); dut3 uses SETTLE=3 with f_in tied high.
module tb_kmap_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  int   checks;
  int   failures;
  logic fForce;
  logic fVal;

  always #5 clk = ~clk;

  kmap_sweeper_if bus1();
  kmap_sweeper_if bus3();

  function automatic logic fModel(input logic [3:0] v);
    return (v[3] & v[2] & ~v[1] & v[0]) | (~v[2] & ~v[0]) | (v[1] & ~v[0]);
  endfunction

  assign bus1.f_in = fForce ? fVal : fModel(bus1.abcd);
  assign bus3.f_in = 1'b1;

  kmap_sweeper #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  kmap_sweeper #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Reset held for two edges with random start and f_in
  task automatic test_reset();
    logic [21:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus1.start = 1'($urandom);
      bus3.start = 1'($urandom);
      fForce     = 1'b1;
      fVal       = 1'($urandom);
      @(posedge clk); #1;
      got = {bus1.busy, bus1.done, bus1.abcd, bus1.table_out};
      checks++;
      if (got !== 22'h0) begin
        failures++;
        $display("FAIL reset.dut1 cyc=%0d got=%h exp=%h", i, got, 22'h0);
      end
      got = {bus3.busy, bus3.done, bus3.abcd, bus3.table_out};
      checks++;
      if (got !== 22'h0) begin
        failures++;
        $display("FAIL reset.dut3 cyc=%0d got=%h exp=%h", i, got, 22'h0);
      end
`ifdef SWEEP_CMP_EN
      checks++;
      if ({bus1.mismatch, bus3.mismatch} !== 2'b00) begin
        failures++;
        $display("FAIL reset.mismatch got=%b exp=00", {bus1.mismatch, bus3.mismatch});
      end
`endif
    end
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    fForce     = 1'b0;
    rst_n      = 1'b1;
  endtask

  // One full SETTLE=1 sweep on dut1, optionally re-pulsing start mid-sweep
  // (vector 5) and in the FINISH cycle.
  task automatic test_sweep(input string name, input logic [15:0] expMask,
                            input logic expMism, input bit repulse);
    logic [5:0] got;
    logic [5:0] exp;
    int         doneCount;
`ifdef SWEEP_CMP_EN
    bus1.exp_mask = expMask;
`endif
    doneCount  = 0;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int j = 0; j <= 35; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (repulse && (j == 10 || j == 32)) bus1.start = 1'b1;
      if (repulse && (j == 11 || j == 33)) bus1.start = 1'b0;
      exp = {(j < 32), (j == 32), (j < 32) ? 4'(j / 2) : 4'hF};
      got = {bus1.busy, bus1.done, bus1.abcd};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s.cycle j=%0d busy_done_abcd got=%h exp=%h", name, j, got, exp);
      end
      if (bus1.done === 1'b1) doneCount++;
      if (j == 0) begin
        checks++;
        if (bus1.table_out !== 16'h0) begin
          failures++;
          $display("FAIL %s.table_clear got=%h exp=0000", name, bus1.table_out);
        end
`ifdef SWEEP_CMP_EN
        checks++;
        if (bus1.mismatch !== 1'b0) begin
          failures++;
          $display("FAIL %s.mism_clear got=%b exp=0", name, bus1.mismatch);
        end
`endif
      end
      if (j == 32 || j == 35) begin
        checks++;
        if (bus1.table_out !== 16'h6545) begin
          failures++;
          $display("FAIL %s.table j=%0d got=%h exp=6545", name, j, bus1.table_out);
        end
`ifdef SWEEP_CMP_EN
        checks++;
        if (bus1.mismatch !== expMism) begin
          failures++;
          $display("FAIL %s.mismatch j=%0d got=%b exp=%b", name, j, bus1.mismatch, expMism);
        end
`endif
      end
    end
    checks++;
    if (doneCount != 1) begin
      failures++;
      $display("FAIL %s.done_count got=%0d exp=1", name, doneCount);
    end
  endtask

  // Reset asserted for one edge while abcd==7; no done may follow
  task automatic test_reset_mid();
    logic [21:0] got;
    int          doneCount;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus1.abcd !== 4'd7) begin
      failures++;
      $display("FAIL reset_mid.pre_abcd got=%h exp=7", bus1.abcd);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = {bus1.busy, bus1.done, bus1.abcd, bus1.table_out};
    checks++;
    if (got !== 22'h0) begin
      failures++;
      $display("FAIL reset_mid.state got=%h exp=%h", got, 22'h0);
    end
    doneCount = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (bus1.done === 1'b1 || bus1.busy === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount != 0) begin
      failures++;
      $display("FAIL reset_mid.no_activity got=%0d exp=0", doneCount);
    end
  endtask

  // start held high: the next sweep begins on the IDLE cycle after FINISH
  task automatic test_back_to_back();
    logic [5:0] got;
    logic [5:0] exp;
    logic [3:0] expAbcd;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j <= 36; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (j < 32)      expAbcd = 4'(j / 2);
      else if (j < 34) expAbcd = 4'hF;
      else             expAbcd = 4'((j - 34) / 2);
      exp = {(j < 32 || j >= 34), (j == 32), expAbcd};
      got = {bus1.busy, bus1.done, bus1.abcd};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b.cycle j=%0d busy_done_abcd got=%h exp=%h", j, got, exp);
      end
      if (j == 32 || j == 34) begin
        checks++;
        if (bus1.table_out !== ((j == 32) ? 16'h6545 : 16'h0)) begin
          failures++;
          $display("FAIL b2b.table j=%0d got=%h exp=%h", j, bus1.table_out,
                   (j == 32) ? 16'h6545 : 16'h0);
        end
      end
    end
    bus1.start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // SETTLE=3 sweep on dut3 with f_in tied high
  task automatic test_settle3();
    logic [5:0] got;
    logic [5:0] exp;
`ifdef SWEEP_CMP_EN
    bus3.exp_mask = 16'hFFFF;
`endif
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    for (int j = 0; j <= 66; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      exp = {(j < 64), (j == 64), (j < 64) ? 4'(j / 4) : 4'hF};
      got = {bus3.busy, bus3.done, bus3.abcd};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL settle3.cycle j=%0d busy_done_abcd got=%h exp=%h", j, got, exp);
      end
      if (j == 64) begin
        checks++;
        if (bus3.table_out !== 16'hFFFF) begin
          failures++;
          $display("FAIL settle3.table got=%h exp=ffff", bus3.table_out);
        end
`ifdef SWEEP_CMP_EN
        checks++;
        if (bus3.mismatch !== 1'b0) begin
          failures++;
          $display("FAIL settle3.mismatch got=%b exp=0", bus3.mismatch);
        end
`endif
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    fForce     = 1'b0;
    fVal       = 1'b0;
`ifdef SWEEP_CMP_EN
    bus1.exp_mask = 16'h6545;
    bus3.exp_mask = 16'hFFFF;
`endif
    test_reset();
    @(posedge clk); #1;
    test_sweep("nominal", 16'h6545, 1'b0, 1'b0);
    test_sweep("cmp_err", 16'h6544, 1'b1, 1'b0);
    test_sweep("repulse", 16'h6545, 1'b0, 1'b1);
    test_reset_mid();
    test_sweep("after_reset", 16'h6545, 1'b0, 1'b0);
    test_back_to_back();
    test_settle3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kmap_sweeper.md
KMAP_SWEEPER -- requirements
Module: kmap_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 1..15, giving the wait cycles per input vector before sampling.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-005 The block SHALL have port abcd, output, 4 bits: stimulus to the function under test, with abcd[3]=A, abcd[2]=B, abcd[1]=C, abcd[0]=D.
REQ-006 The block SHALL have port f_in, input, 1 bit: the response F of the function under test.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-009 The block SHALL have port table_out, output, 16 bits: the captured truth table, where bit i holds F for abcd==i.
REQ-010 When SWEEP_CMP_EN is defined, the block SHALL have port exp_mask, input, 16 bits (expected truth table), and port mismatch, output, 1 bit.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SETTLE, CAPTURE and FINISH.
REQ-012 In IDLE, when start=1, the block SHALL set idx=0, abcd=0, cnt=0 and table_out=0, then move to SETTLE.
REQ-013 In SETTLE, the block SHALL increment cnt each cycle and move to CAPTURE after exactly SETTLE cycles.
REQ-014 In CAPTURE, the block SHALL write table_out[idx]<=f_in; if idx==15 it SHALL move to FINISH, otherwise it SHALL set idx<=idx+1, abcd<=idx+1 and cnt<=0, and return to SETTLE.
REQ-015 In FINISH, the block SHALL assert done=1 for that single cycle and then move to IDLE.
REQ-016 busy SHALL be 1 exactly in SETTLE and CAPTURE, and 0 in IDLE and FINISH.
REQ-017 For a start sampled at edge T, vector k SHALL be captured at edge T+(k+1)*(SETTLE+1), and done SHALL be high in the cycle after edge T+16*(SETTLE+1); for SETTLE=1 this is T+32.
REQ-018 start SHALL be ignored in SETTLE, CAPTURE and FINISH; it SHALL NOT restart, extend or re-pulse a sweep.
REQ-019 A start held high continuously SHALL launch a new sweep on the first IDLE cycle after FINISH.
REQ-020 table_out SHALL hold its value from done until the next accepted start.
REQ-021 After FINISH, abcd SHALL hold 4'hF until the next accepted start.
REQ-022 The vector index SHALL be exactly 4 bits wide, and the sweep SHALL terminate on idx==15 without wrapping to 0.

Reset
REQ-023 While rst_n=0 at a rising clk edge, the block SHALL enter IDLE with abcd=0, table_out=0, busy=0, done=0, idx=0, cnt=0 and mismatch=0 (when present).
REQ-024 Reset SHALL take priority over start and over any state, including mid-sweep; a partial table SHALL be discarded and no done SHALL be produced.
REQ-025 The block SHALL have no asynchronous reset path.

Configuration
REQ-026 With macro SWEEP_CMP_EN defined, mismatch SHALL be registered, cleared on an accepted start, and valid in the same cycle as done.
REQ-027 With SWEEP_CMP_EN defined, mismatch SHALL equal (completed table != exp_mask), and the completed table SHALL include the final f_in sample.
REQ-028 With SWEEP_CMP_EN defined, mismatch SHALL hold its value until the next accepted start or reset.
REQ-029 Without SWEEP_CMP_EN, the ports exp_mask and mismatch SHALL be absent and no comparison logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: rst_n=0 for 2 cycles with random start and f_in -> abcd=0, table_out=0, busy=0, done=0, mismatch=0.
REQ-031 The bench SHALL cover: SETTLE=1, f_in from model F=ABC'D+B'D'+CD', one start pulse at edge T -> abcd steps 0..15 every 2 cycles, done high in the single cycle after edge T+32, table_out=16'h6545, and mismatch=0 with exp_mask=16'h6545.
REQ-032 The bench SHALL cover: the same sweep with exp_mask=16'h6544 (SWEEP_CMP_EN) -> mismatch=1 alongside done, cleared on the next start.
REQ-033 The bench SHALL cover: start re-pulsed at vector 5 and at the FINISH cycle -> exactly one done, unchanged abcd sequence, and busy low in the FINISH cycle.
REQ-034 The bench SHALL cover: rst_n=0 for one edge while abcd==7 -> IDLE with table_out=0, abcd=0 and no done; a following start gives a full correct sweep.
REQ-035 The bench SHALL cover: SETTLE=3, f_in tied 1 -> table_out=16'hFFFF, and done high in the cycle after edge T+64.
